// File: rtl/alu_issue_ctrl_if.sv
// Operation and result handshake channels between upstream, alu_issue_ctrl and downstream.
// The master drives operations and result-ready; the slave (the issue stage) answers.
interface alu_issue_ctrl_if;
    logic        OpValid;
    logic        OpReady;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic [4:0]  OpFunSel;
    logic        OpWF;
    logic        ResValid;
    logic        ResReady;
    logic [31:0] ResData;
    logic [3:0]  ResFlags;

    modport master (
        output OpValid, OpA, OpB, OpFunSel, OpWF, ResReady,
        input  OpReady, ResValid, ResData, ResFlags
    );

    modport slave (
        input  OpValid, OpA, OpB, OpFunSel, OpWF, ResReady,
        output OpReady, ResValid, ResData, ResFlags
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue handshake stage in front of a registered ALU: accept, execute, capture, hand off.
// Only one operation is in flight, so ALU flag updates (used by ADC/CSL/CSR) stay in order.
module alu_issue_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    alu_issue_ctrl_if.slave    bus,
    output logic [31:0]        ALU_A,
    output logic [31:0]        ALU_B,
    output logic [4:0]         ALU_FunSel,
    output logic               ALU_WF,
    input  logic [31:0]        ALUOut,
    input  logic [3:0]         FlagsOut,
    output logic               Busy,
    output logic [CNT_W-1:0]   OpCount
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, DONE} state_e;

    state_e             state_q, state_d;
    logic [31:0]        a_q, b_q;
    logic [4:0]         fun_sel_q;
    logic               wf_q;
    logic [31:0]        res_data_q;
    logic [3:0]         res_flags_q;
    logic [CNT_W-1:0]   op_count_q;

    logic               op_ready;
    logic               res_valid;
    logic               alu_wf;
    logic               accept;
    logic               handoff;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        alu_wf    = 1'b0;
        accept    = 1'b0;
        handoff   = 1'b0;
        unique case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                if (bus.OpValid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_wf  = wf_q;
                state_d = CAPT;
            end
            CAPT: state_d = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (bus.ResReady) begin
                    handoff  = 1'b1;
                    op_ready = 1'b1;
                    if (bus.OpValid) begin
                        accept  = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // The ALU rewrites its flags on every clock with WF high, so reset must silence it too.
        if (Reset) begin
            op_ready = 1'b0;
            alu_wf   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            fun_sel_q   <= '0;
            wf_q        <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            op_count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q       <= bus.OpA;
                b_q       <= bus.OpB;
                fun_sel_q <= bus.OpFunSel;
                wf_q      <= bus.OpWF;
            end
            // ALUOut/FlagsOut were registered by the ALU at the end of EXEC.
            if (state_q == CAPT) begin
                res_data_q  <= ALUOut;
                res_flags_q <= FlagsOut;
            end
            if (handoff) begin
                op_count_q <= op_count_q + 1'b1;
            end
        end
    end

    assign bus.OpReady  = op_ready;
    assign bus.ResValid = res_valid;
    assign bus.ResData  = res_data_q;
    assign bus.ResFlags = res_flags_q;

    assign ALU_A      = a_q;
    assign ALU_B      = b_q;
    assign ALU_FunSel = fun_sel_q;
    assign ALU_WF     = alu_wf;
    assign Busy       = (state_q != IDLE);
    assign OpCount    = op_count_q;

endmodule
